// File: rtl/axil_rr_arbiter.sv
// axil_rr_arbiter: round-robin MASTER_NUM:1 AXI4-Lite arbiter.
// Write (AW/W/B) and read (AR/R) channels are arbitrated independently, one
// outstanding transaction per channel. Grants are registered one-hot vectors.
// Ports:
//   clk_i, rstn_i         clock, asynchronous active-low reset
//   s_axil_*              per-master slave ports (packed [MASTER_NUM-1:0] arrays)
//   m_axil_*              single master port toward the shared slave
//   wr_grant_o/rd_grant_o one-hot current owner per channel, 0 when idle
// Optional feature macro: AXIL_ARB_TIMEOUT_EN (response watchdog returning
// SLVERR after TIMEOUT_CYCLES, then draining the late response).
module axil_rr_arbiter #(
    parameter int unsigned MASTER_NUM     = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                   clk_i,
    input  logic                                   rstn_i,
    input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0]  s_axil_awaddr_i,
    input  logic [MASTER_NUM-1:0]                  s_axil_awvalid_i,
    output logic [MASTER_NUM-1:0]                  s_axil_awready_o,
    input  logic [MASTER_NUM-1:0][DATA_WIDTH-1:0]  s_axil_wdata_i,
    input  logic [MASTER_NUM-1:0][DATA_WIDTH/8-1:0] s_axil_wstrb_i,
    input  logic [MASTER_NUM-1:0]                  s_axil_wvalid_i,
    output logic [MASTER_NUM-1:0]                  s_axil_wready_o,
    output logic [MASTER_NUM-1:0][1:0]             s_axil_bresp_o,
    output logic [MASTER_NUM-1:0]                  s_axil_bvalid_o,
    input  logic [MASTER_NUM-1:0]                  s_axil_bready_i,
    input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0]  s_axil_araddr_i,
    input  logic [MASTER_NUM-1:0]                  s_axil_arvalid_i,
    output logic [MASTER_NUM-1:0]                  s_axil_arready_o,
    output logic [MASTER_NUM-1:0][DATA_WIDTH-1:0]  s_axil_rdata_o,
    output logic [MASTER_NUM-1:0][1:0]             s_axil_rresp_o,
    output logic [MASTER_NUM-1:0]                  s_axil_rvalid_o,
    input  logic [MASTER_NUM-1:0]                  s_axil_rready_i,
    output logic [ADDR_WIDTH-1:0]                  m_axil_awaddr_o,
    output logic                                   m_axil_awvalid_o,
    input  logic                                   m_axil_awready_i,
    output logic [DATA_WIDTH-1:0]                  m_axil_wdata_o,
    output logic [DATA_WIDTH/8-1:0]                m_axil_wstrb_o,
    output logic                                   m_axil_wvalid_o,
    input  logic                                   m_axil_wready_i,
    input  logic [1:0]                             m_axil_bresp_i,
    input  logic                                   m_axil_bvalid_i,
    output logic                                   m_axil_bready_o,
    output logic [ADDR_WIDTH-1:0]                  m_axil_araddr_o,
    output logic                                   m_axil_arvalid_o,
    input  logic                                   m_axil_arready_i,
    input  logic [DATA_WIDTH-1:0]                  m_axil_rdata_i,
    input  logic [1:0]                             m_axil_rresp_i,
    input  logic                                   m_axil_rvalid_i,
    output logic                                   m_axil_rready_o,
    output logic [MASTER_NUM-1:0]                  wr_grant_o,
    output logic [MASTER_NUM-1:0]                  rd_grant_o
);

    localparam int unsigned PTR_W       = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    if (MASTER_NUM < 2 || TIMEOUT_CYCLES < 1 || (DATA_WIDTH % 8) != 0) begin : g_param_check
        $error("axil_rr_arbiter: illegal parameter combination");
    end

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP, W_DRAIN} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DRAIN} rd_state_t;
    logic [CNT_W-1:0] r_wr_cnt, w_wr_cnt_nx, r_rd_cnt, w_rd_cnt_nx;
`else
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
`endif

    wr_state_t             r_wr_state, w_wr_state_nx;
    rd_state_t             r_rd_state, w_rd_state_nx;
    logic [MASTER_NUM-1:0] r_wr_grant, w_wr_grant_nx, r_rd_grant, w_rd_grant_nx;
    logic [PTR_W-1:0]      r_wr_owner, w_wr_owner_nx, r_wr_ptr, w_wr_ptr_nx, w_wr_win;
    logic [PTR_W-1:0]      r_rd_owner, w_rd_owner_nx, r_rd_ptr, w_rd_ptr_nx, w_rd_win;
    logic                  r_aw_done, w_aw_done_nx, r_w_done, w_w_done_nx;
    logic                  w_aw_open, w_w_open, w_ar_open;
    logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic                  w_wr_to, w_rd_to, w_wr_drain, w_rd_drain;

`ifdef AXIL_ARB_TIMEOUT_EN
    assign w_wr_to    = (r_wr_state == W_RESP) && (r_wr_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign w_rd_to    = (r_rd_state == R_DATA) && (r_rd_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign w_wr_drain = (r_wr_state == W_DRAIN);
    assign w_rd_drain = (r_rd_state == R_DRAIN);
`else
    assign w_wr_to    = 1'b0;
    assign w_rd_to    = 1'b0;
    assign w_wr_drain = 1'b0;
    assign w_rd_drain = 1'b0;
`endif

    // Round-robin pick: descending scan so the requester nearest ptr+1 wins last.
    always_comb begin : rr_pick
        logic [PTR_W-1:0] v_idx;
        w_wr_win = r_wr_ptr;
        w_rd_win = r_rd_ptr;
        for (int k = int'(MASTER_NUM); k >= 1; k--) begin
            v_idx = PTR_W'((int'(r_wr_ptr) + k) % int'(MASTER_NUM));
            if (s_axil_awvalid_i[v_idx]) w_wr_win = v_idx;
            v_idx = PTR_W'((int'(r_rd_ptr) + k) % int'(MASTER_NUM));
            if (s_axil_arvalid_i[v_idx]) w_rd_win = v_idx;
        end
    end

    // Write channel muxing toward the owner only.
    assign w_aw_open        = (r_wr_state == W_ADDR) && !r_aw_done;
    assign w_w_open         = (r_wr_state == W_ADDR) && !r_w_done;
    assign m_axil_awaddr_o  = s_axil_awaddr_i[r_wr_owner];
    assign m_axil_awvalid_o = w_aw_open && s_axil_awvalid_i[r_wr_owner];
    assign m_axil_wdata_o   = s_axil_wdata_i[r_wr_owner];
    assign m_axil_wstrb_o   = s_axil_wstrb_i[r_wr_owner];
    assign m_axil_wvalid_o  = w_w_open && s_axil_wvalid_i[r_wr_owner];
    assign w_aw_hs          = m_axil_awvalid_o && m_axil_awready_i;
    assign w_w_hs           = m_axil_wvalid_o && m_axil_wready_i;
    assign s_axil_awready_o = r_wr_grant & {MASTER_NUM{w_aw_open && m_axil_awready_i}};
    assign s_axil_wready_o  = r_wr_grant & {MASTER_NUM{w_w_open && m_axil_wready_i}};
    assign m_axil_bready_o  = ((r_wr_state == W_RESP) && !w_wr_to && s_axil_bready_i[r_wr_owner])
                              || w_wr_drain;
    assign s_axil_bvalid_o  = r_wr_grant & {MASTER_NUM{(r_wr_state == W_RESP) && (w_wr_to || m_axil_bvalid_i)}};
    assign s_axil_bresp_o   = {MASTER_NUM{w_wr_to ? RESP_SLVERR : m_axil_bresp_i}};
    assign w_b_hs           = (r_wr_state == W_RESP) && s_axil_bready_i[r_wr_owner]
                              && (w_wr_to || m_axil_bvalid_i);
    assign wr_grant_o       = r_wr_grant;

    // Read channel muxing toward the owner only.
    assign w_ar_open        = (r_rd_state == R_ADDR);
    assign m_axil_araddr_o  = s_axil_araddr_i[r_rd_owner];
    assign m_axil_arvalid_o = w_ar_open && s_axil_arvalid_i[r_rd_owner];
    assign w_ar_hs          = m_axil_arvalid_o && m_axil_arready_i;
    assign s_axil_arready_o = r_rd_grant & {MASTER_NUM{w_ar_open && m_axil_arready_i}};
    assign m_axil_rready_o  = ((r_rd_state == R_DATA) && !w_rd_to && s_axil_rready_i[r_rd_owner])
                              || w_rd_drain;
    assign s_axil_rvalid_o  = r_rd_grant & {MASTER_NUM{(r_rd_state == R_DATA) && (w_rd_to || m_axil_rvalid_i)}};
    assign s_axil_rresp_o   = {MASTER_NUM{w_rd_to ? RESP_SLVERR : m_axil_rresp_i}};
    assign s_axil_rdata_o   = {MASTER_NUM{w_rd_to ? DATA_WIDTH'(0) : m_axil_rdata_i}};
    assign w_r_hs           = (r_rd_state == R_DATA) && s_axil_rready_i[r_rd_owner]
                              && (w_rd_to || m_axil_rvalid_i);
    assign rd_grant_o       = r_rd_grant;

    // Write FSM next state.
    always_comb begin : wr_next
        w_wr_state_nx = r_wr_state;
        w_wr_grant_nx = r_wr_grant;
        w_wr_owner_nx = r_wr_owner;
        w_wr_ptr_nx   = r_wr_ptr;
        w_aw_done_nx  = r_aw_done;
        w_w_done_nx   = r_w_done;
`ifdef AXIL_ARB_TIMEOUT_EN
        w_wr_cnt_nx   = '0;
`endif
        case (r_wr_state)
            W_IDLE: begin
                if (|s_axil_awvalid_i) begin
                    w_wr_state_nx = W_ADDR;
                    w_wr_owner_nx = w_wr_win;
                    w_wr_grant_nx = MASTER_NUM'(1) << w_wr_win;
                    w_aw_done_nx  = 1'b0;
                    w_w_done_nx   = 1'b0;
                end
            end
            W_ADDR: begin
                w_aw_done_nx = r_aw_done | w_aw_hs;
                w_w_done_nx  = r_w_done | w_w_hs;
                if (w_aw_done_nx && w_w_done_nx) w_wr_state_nx = W_RESP;
            end
            W_RESP: begin
                if (w_b_hs) begin
                    w_wr_ptr_nx   = r_wr_owner;
                    w_wr_grant_nx = '0;
`ifdef AXIL_ARB_TIMEOUT_EN
                    w_wr_state_nx = w_wr_to ? W_DRAIN : W_IDLE;
                end else if (!w_wr_to && !m_axil_bvalid_i) begin
                    w_wr_cnt_nx   = r_wr_cnt + CNT_W'(1);
                end else begin
                    w_wr_cnt_nx   = r_wr_cnt;
`else
                    w_wr_state_nx = W_IDLE;
`endif
                end
            end
`ifdef AXIL_ARB_TIMEOUT_EN
            W_DRAIN: begin
                if (m_axil_bvalid_i) w_wr_state_nx = W_IDLE;
            end
`endif
            default: w_wr_state_nx = W_IDLE;
        endcase
    end

    // Read FSM next state.
    always_comb begin : rd_next
        w_rd_state_nx = r_rd_state;
        w_rd_grant_nx = r_rd_grant;
        w_rd_owner_nx = r_rd_owner;
        w_rd_ptr_nx   = r_rd_ptr;
`ifdef AXIL_ARB_TIMEOUT_EN
        w_rd_cnt_nx   = '0;
`endif
        case (r_rd_state)
            R_IDLE: begin
                if (|s_axil_arvalid_i) begin
                    w_rd_state_nx = R_ADDR;
                    w_rd_owner_nx = w_rd_win;
                    w_rd_grant_nx = MASTER_NUM'(1) << w_rd_win;
                end
            end
            R_ADDR: begin
                if (w_ar_hs) w_rd_state_nx = R_DATA;
            end
            R_DATA: begin
                if (w_r_hs) begin
                    w_rd_ptr_nx   = r_rd_owner;
                    w_rd_grant_nx = '0;
`ifdef AXIL_ARB_TIMEOUT_EN
                    w_rd_state_nx = w_rd_to ? R_DRAIN : R_IDLE;
                end else if (!w_rd_to && !m_axil_rvalid_i) begin
                    w_rd_cnt_nx   = r_rd_cnt + CNT_W'(1);
                end else begin
                    w_rd_cnt_nx   = r_rd_cnt;
`else
                    w_rd_state_nx = R_IDLE;
`endif
                end
            end
`ifdef AXIL_ARB_TIMEOUT_EN
            R_DRAIN: begin
                if (m_axil_rvalid_i) w_rd_state_nx = R_IDLE;
            end
`endif
            default: w_rd_state_nx = R_IDLE;
        endcase
    end

    // State registers; pointers reset to the last master so master 0 wins first.
    always_ff @(posedge clk_i or negedge rstn_i) begin : state_regs
        if (!rstn_i) begin
            r_wr_state <= W_IDLE;
            r_wr_grant <= '0;
            r_wr_owner <= '0;
            r_wr_ptr   <= PTR_W'(MASTER_NUM - 1);
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_rd_state <= R_IDLE;
            r_rd_grant <= '0;
            r_rd_owner <= '0;
            r_rd_ptr   <= PTR_W'(MASTER_NUM - 1);
`ifdef AXIL_ARB_TIMEOUT_EN
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
`endif
        end else begin
            r_wr_state <= w_wr_state_nx;
            r_wr_grant <= w_wr_grant_nx;
            r_wr_owner <= w_wr_owner_nx;
            r_wr_ptr   <= w_wr_ptr_nx;
            r_aw_done  <= w_aw_done_nx;
            r_w_done   <= w_w_done_nx;
            r_rd_state <= w_rd_state_nx;
            r_rd_grant <= w_rd_grant_nx;
            r_rd_owner <= w_rd_owner_nx;
            r_rd_ptr   <= w_rd_ptr_nx;
`ifdef AXIL_ARB_TIMEOUT_EN
            r_wr_cnt   <= w_wr_cnt_nx;
            r_rd_cnt   <= w_rd_cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Directed testbench for axil_rr_arbiter with two masters.
module tb_axil_rr_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [N-1:0][AW-1:0] s_awaddr, s_araddr;
    logic [N-1:0][DW-1:0] s_wdata, s_rdata;
    logic [N-1:0][3:0]    s_wstrb;
    logic [N-1:0][1:0]    s_bresp, s_rresp;
    logic [N-1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [N-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [3:0]    m_wstrb;
    logic [1:0]    m_bresp, m_rresp;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic m_arvalid, m_arready, m_rvalid, m_rready;
    logic [N-1:0] wr_grant, rd_grant;

    int checks   = 0;
    int failures = 0;

    axil_rr_arbiter #(.MASTER_NUM(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .s_axil_awaddr_i(s_awaddr), .s_axil_awvalid_i(s_awvalid), .s_axil_awready_o(s_awready),
        .s_axil_wdata_i(s_wdata), .s_axil_wstrb_i(s_wstrb), .s_axil_wvalid_i(s_wvalid),
        .s_axil_wready_o(s_wready), .s_axil_bresp_o(s_bresp), .s_axil_bvalid_o(s_bvalid),
        .s_axil_bready_i(s_bready), .s_axil_araddr_i(s_araddr), .s_axil_arvalid_i(s_arvalid),
        .s_axil_arready_o(s_arready), .s_axil_rdata_o(s_rdata), .s_axil_rresp_o(s_rresp),
        .s_axil_rvalid_o(s_rvalid), .s_axil_rready_i(s_rready),
        .m_axil_awaddr_o(m_awaddr), .m_axil_awvalid_o(m_awvalid), .m_axil_awready_i(m_awready),
        .m_axil_wdata_o(m_wdata), .m_axil_wstrb_o(m_wstrb), .m_axil_wvalid_o(m_wvalid),
        .m_axil_wready_i(m_wready), .m_axil_bresp_i(m_bresp), .m_axil_bvalid_i(m_bvalid),
        .m_axil_bready_o(m_bready), .m_axil_araddr_o(m_araddr), .m_axil_arvalid_o(m_arvalid),
        .m_axil_arready_i(m_arready), .m_axil_rdata_i(m_rdata), .m_axil_rresp_i(m_rresp),
        .m_axil_rvalid_i(m_rvalid), .m_axil_rready_o(m_rready),
        .wr_grant_o(wr_grant), .rd_grant_o(rd_grant)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        s_awaddr = '0; s_awvalid = '0; s_wdata = '0; s_wstrb = '0; s_wvalid = '0; s_bready = '0;
        s_araddr = '0; s_arvalid = '0; s_rready = '0;
        m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
        m_arready = 0; m_rdata = 0; m_rresp = 0; m_rvalid = 0;
    endtask

    task automatic do_reset();
        rstn = 0;
        zero_inputs();
        repeat (2) cyc();
        rstn = 1;
        cyc();
    endtask

    // Slave-side driver: accept AW+W in one cycle, record the owner and payload, return B OKAY.
    task automatic slave_wr(output logic [N-1:0] g, output logic [AW-1:0] a,
                            output logic [DW-1:0] d, output bit ok);
        bit seen;
        int idx;
        seen = 0; g = '0; a = '0; d = '0;
        for (int k = 0; k < 20 && !seen; k++) begin
            #1;
            if (m_awvalid && m_wvalid) seen = 1;
            else cyc();
        end
        ok = seen;
        if (!seen) return;
        g = wr_grant; a = m_awaddr; d = m_wdata;
        idx = wr_grant[1] ? 1 : 0;
        m_awready = 1; m_wready = 1;
        cyc();
        s_awvalid[idx] = 0; s_wvalid[idx] = 0;
        m_awready = 0; m_wready = 0;
        m_bvalid = 1; m_bresp = 2'b00;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            #1;
            if (m_bready) seen = 1;
            else cyc();
        end
        ok = seen;
        if (seen) cyc();
        m_bvalid = 0;
    endtask

    task automatic test_reset();
        rstn = 0;
        zero_inputs();
        s_awvalid = 2'b11; s_arvalid = 2'b11; s_bready = 2'b11; s_rready = 2'b11;
        cyc(); #1;
        checks++; if ({wr_grant, rd_grant} !== 4'b0) begin failures++; $display("FAIL reset_grants: got %b want 0000", {wr_grant, rd_grant}); end
        checks++; if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0) begin failures++; $display("FAIL reset_m_ctrl: got %b want 00000", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}); end
        checks++; if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 10'b0) begin failures++; $display("FAIL reset_s_ctrl: got %b want 0", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}); end
        zero_inputs();
        rstn = 1;
        cyc();
    endtask

    task automatic test_single_write();
        s_awaddr[0] = 32'h43c0_0004; s_wdata[0] = 32'h0000_00A5; s_wstrb[0] = 4'hF;
        s_awvalid[0] = 1; s_wvalid[0] = 1; s_bready = 2'b11;
        #1;
        checks++; if (wr_grant !== 2'b00) begin failures++; $display("FAIL t1_grant_latency: got %b want 00", wr_grant); end
        cyc();
        checks++; if (wr_grant !== 2'b01) begin failures++; $display("FAIL t1_grant: got %b want 01", wr_grant); end
        checks++; if ({m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb} !== {2'b11, 32'h43c0_0004, 32'h0000_00A5, 4'hF}) begin
            failures++; $display("FAIL t1_aw_w_mux: got v=%b a=%h d=%h s=%h", {m_awvalid, m_wvalid}, m_awaddr, m_wdata, m_wstrb); end
        m_awready = 1; m_wready = 1; #1;
        checks++; if ({s_awready, s_wready} !== 4'b0101) begin failures++; $display("FAIL t1_ready_route: got %b want 0101", {s_awready, s_wready}); end
        cyc();
        s_awvalid[0] = 0; s_wvalid[0] = 0; m_awready = 0; m_wready = 0; #1;
        checks++; if ({m_bready, m_awvalid, m_wvalid} !== 3'b100) begin failures++; $display("FAIL t1_resp_state: got %b want 100", {m_bready, m_awvalid, m_wvalid}); end
        m_bvalid = 1; m_bresp = 2'b00; #1;
        checks++; if (s_bvalid !== 2'b01 || s_bresp[0] !== 2'b00) begin failures++; $display("FAIL t1_b_route: got bvalid=%b bresp=%b want 01/00", s_bvalid, s_bresp[0]); end
        cyc();
        m_bvalid = 0; #1;
        checks++; if (wr_grant !== 2'b00 || s_bvalid !== 2'b00) begin failures++; $display("FAIL t1_done: got grant=%b bvalid=%b want 00/00", wr_grant, s_bvalid); end
        s_bready = '0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit ok;
        int em;
        do_reset();
        s_awaddr[0] = 32'h0000_0100; s_wdata[0] = 32'hA0;
        s_awaddr[1] = 32'h0000_0200; s_wdata[1] = 32'hB0;
        s_wstrb = '1; s_bready = 2'b11;
        s_awvalid = 2'b11; s_wvalid = 2'b11;
        for (int r = 0; r < 4; r++) begin
            em = r % 2;
            slave_wr(g, a, d, ok);
            checks++; if (!ok) begin failures++; $display("FAIL t2_timeout round %0d: got no handshake want handshake", r); end
            checks++; if (g !== (2'b01 << em)) begin failures++; $display("FAIL t2_order round %0d: got %b want %b", r, g, 2'b01 << em); end
            checks++; if (d !== (em ? 32'hB0 : 32'hA0) + 32'(r / 2) || a !== (em ? 32'h200 : 32'h100)) begin
                failures++; $display("FAIL t2_data round %0d: got a=%h d=%h", r, a, d); end
            if (r < 2) begin
                s_wdata[em] = s_wdata[em] + 32'd1;
                s_awvalid[em] = 1; s_wvalid[em] = 1;
            end
        end
        s_bready = '0;
    endtask

    task automatic test_concurrent_rw();
        s_araddr[0] = 32'h10; s_arvalid[0] = 1; s_rready[0] = 1;
        s_awaddr[1] = 32'h20; s_wdata[1] = 32'h77; s_awvalid[1] = 1; s_wvalid[1] = 1; s_bready[1] = 1;
        cyc();
        checks++; if (rd_grant !== 2'b01 || wr_grant !== 2'b10) begin failures++; $display("FAIL t3_grants: got rd=%b wr=%b want 01/10", rd_grant, wr_grant); end
        checks++; if (!m_arvalid || m_araddr !== 32'h10 || !m_awvalid || m_wdata !== 32'h77) begin failures++; $display("FAIL t3_mux: got arv=%b ara=%h awv=%b wd=%h", m_arvalid, m_araddr, m_awvalid, m_wdata); end
        m_arready = 1; m_awready = 1; m_wready = 1; #1;
        checks++; if (s_arready !== 2'b01 || s_awready !== 2'b10) begin failures++; $display("FAIL t3_ready: got ar=%b aw=%b want 01/10", s_arready, s_awready); end
        cyc();
        s_arvalid[0] = 0; s_awvalid[1] = 0; s_wvalid[1] = 0;
        m_arready = 0; m_awready = 0; m_wready = 0;
        m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00; m_bvalid = 1; m_bresp = 2'b00; #1;
        checks++; if (s_rvalid !== 2'b01 || s_rdata[0] !== 32'hDEAD_BEEF || s_bvalid !== 2'b10) begin
            failures++; $display("FAIL t3_resp_route: got rv=%b rd=%h bv=%b want 01/deadbeef/10", s_rvalid, s_rdata[0], s_bvalid); end
        cyc();
        m_rvalid = 0; m_bvalid = 0; #1;
        checks++; if ({rd_grant, wr_grant} !== 4'b0) begin failures++; $display("FAIL t3_done: got %b want 0000", {rd_grant, wr_grant}); end
        s_rready = '0; s_bready = '0;
    endtask

    task automatic test_w_before_aw();
        logic [N-1:0] g;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit ok;
        s_awaddr[0] = 32'h30; s_wdata[0] = 32'h11; s_awvalid[0] = 1; s_wvalid[0] = 1; s_bready[0] = 1;
        cyc();
        m_wready = 1; #1;
        checks++; if (s_wready !== 2'b01 || s_awready !== 2'b00) begin failures++; $display("FAIL t4_w_only: got w=%b aw=%b want 01/00", s_wready, s_awready); end
        cyc();
        m_wready = 0; #1;
        checks++; if (m_wvalid !== 1'b0 || m_awvalid !== 1'b1 || m_bready !== 1'b0) begin failures++; $display("FAIL t4_w_done: got wv=%b awv=%b br=%b want 0/1/0", m_wvalid, m_awvalid, m_bready); end
        cyc(); #1;
        checks++; if (m_awvalid !== 1'b1 || m_bready !== 1'b0) begin failures++; $display("FAIL t4_wait_aw: got awv=%b br=%b want 1/0", m_awvalid, m_bready); end
        m_awready = 1;
        cyc();
        s_awvalid[0] = 0; s_wvalid[0] = 0; m_awready = 0; #1;
        checks++; if (m_bready !== 1'b1 || m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin failures++; $display("FAIL t4_resp: got br=%b awv=%b wv=%b want 1/0/0", m_bready, m_awvalid, m_wvalid); end
        m_bvalid = 1; #1;
        checks++; if (s_bvalid !== 2'b01) begin failures++; $display("FAIL t4_b: got %b want 01", s_bvalid); end
        cyc();
        m_bvalid = 0;
        s_wdata[0] = 32'h22; s_awvalid[0] = 1; s_wvalid[0] = 1;
        slave_wr(g, a, d, ok);
        checks++; if (!ok || g !== 2'b01 || d !== 32'h22) begin failures++; $display("FAIL t4_same_cycle: got ok=%0d g=%b d=%h want 1/01/22", ok, g, d); end
        s_bready = '0;
    endtask

    task automatic test_reset_mid_resp();
        logic [N-1:0] g;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit ok;
        s_awaddr[1] = 32'h40; s_wdata[1] = 32'h55; s_awvalid[1] = 1; s_wvalid[1] = 1; s_bready = 2'b11;
        cyc();
        m_awready = 1; m_wready = 1;
        cyc();
        s_awvalid[1] = 0; s_wvalid[1] = 0; m_awready = 0; m_wready = 0; m_bvalid = 1; #1;
        checks++; if (m_bready !== 1'b1 || s_bvalid !== 2'b10) begin failures++; $display("FAIL t5_pre: got br=%b bv=%b want 1/10", m_bready, s_bvalid); end
        rstn = 0; #1;
        checks++; if ({wr_grant, m_bready, s_bvalid, m_awvalid, m_wvalid} !== 7'b0) begin
            failures++; $display("FAIL t5_async_reset: got %b want 0000000", {wr_grant, m_bready, s_bvalid, m_awvalid, m_wvalid}); end
        zero_inputs();
        cyc();
        rstn = 1;
        s_awaddr[0] = 32'h50; s_wdata[0] = 32'h66; s_awaddr[1] = 32'h60; s_wdata[1] = 32'h77;
        s_awvalid = 2'b11; s_wvalid = 2'b11; s_bready = 2'b11;
        slave_wr(g, a, d, ok);
        checks++; if (!ok || g !== 2'b01 || d !== 32'h66) begin failures++; $display("FAIL t5_after_reset: got ok=%0d g=%b d=%h want 1/01/66", ok, g, d); end
        slave_wr(g, a, d, ok);
        checks++; if (!ok || g !== 2'b10 || d !== 32'h77) begin failures++; $display("FAIL t5_second: got ok=%0d g=%b d=%h want 1/10/77", ok, g, d); end
        s_bready = '0;
    endtask

`ifdef AXIL_ARB_TIMEOUT_EN
    task automatic test_timeout();
        s_araddr[0] = 32'h80; s_arvalid[0] = 1; s_rready[0] = 1;
        m_rdata = 32'hFFFF_FFFF; m_rresp = 2'b00;
        cyc();
        m_arready = 1;
        cyc();
        s_arvalid[0] = 0; m_arready = 0;
        repeat (15) cyc();
        #1;
        checks++; if (s_rvalid !== 2'b00) begin failures++; $display("FAIL t6_early: got %b want 00", s_rvalid); end
        cyc(); #1;
        checks++; if (s_rvalid !== 2'b01 || s_rresp[0] !== 2'b10 || s_rdata[0] !== 32'h0) begin
            failures++; $display("FAIL t6_slverr: got rv=%b rr=%b rd=%h want 01/10/0", s_rvalid, s_rresp[0], s_rdata[0]); end
        s_araddr[1] = 32'h84; s_arvalid[1] = 1; s_rready[1] = 1;
        cyc(); #1;
        checks++; if (m_rready !== 1'b1 || rd_grant !== 2'b00 || s_rvalid !== 2'b00) begin
            failures++; $display("FAIL t6_drain: got rr=%b g=%b rv=%b want 1/00/00", m_rready, rd_grant, s_rvalid); end
        cyc(); #1;
        checks++; if (rd_grant !== 2'b00 || m_arvalid !== 1'b0) begin failures++; $display("FAIL t6_no_grant: got g=%b arv=%b want 00/0", rd_grant, m_arvalid); end
        m_rvalid = 1; #1;
        checks++; if (s_rvalid !== 2'b00) begin failures++; $display("FAIL t6_stale: got %b want 00", s_rvalid); end
        cyc();
        m_rvalid = 0;
        cyc(); #1;
        checks++; if (rd_grant !== 2'b10) begin failures++; $display("FAIL t6_next_grant: got %b want 10", rd_grant); end
        m_arready = 1;
        cyc();
        s_arvalid[1] = 0; m_arready = 0;
        m_rvalid = 1; m_rdata = 32'h1234_5678; m_rresp = 2'b00; #1;
        checks++; if (s_rvalid !== 2'b10 || s_rresp[1] !== 2'b00 || s_rdata[1] !== 32'h1234_5678) begin
            failures++; $display("FAIL t6_okay: got rv=%b rr=%b rd=%h want 10/00/12345678", s_rvalid, s_rresp[1], s_rdata[1]); end
        cyc();
        m_rvalid = 0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 0;
        zero_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_concurrent_rw();
        test_w_before_aw();
        test_reset_mid_resp();
`ifdef AXIL_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
